// File: rtl/stdp_pair_scheduler.sv
// Nearest-neighbour STDP pair former that folds the returned dw into a saturating weight.
// Define STDP_PENDING_EN to add a 1-entry pending buffer for events that arrive while busy.
module stdp_pair_scheduler #(
  parameter int           N      = 32,
  parameter int           Q      = 16,
  parameter int           WINDOW = 64,
  parameter logic [N-1:0] W_MIN  = 32'h0000_0000,
  parameter logic [N-1:0] W_MAX  = 32'h0001_0000,
  parameter logic [N-1:0] W_INIT = 32'h0000_8000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         pre_spike,
  input  logic         post_spike,
  input  logic [N-1:0] dw,
  output logic [N-1:0] t_change,
  output logic         apply,
  output logic [N-1:0] weight,
  output logic         busy,
  output logic         overflow
);

  localparam int            AW      = $clog2(WINDOW + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(WINDOW);
  localparam int            SW      = N + 1;

`ifdef STDP_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, APPLY, UPDATE} state_t;

  function automatic logic signed [SW-1:0] sm2tc(input logic [N-1:0] x);
    logic signed [SW-1:0] m;
    m = $signed(SW'(x[N-2:0]));
    return x[N-1] ? -m : m;
  endfunction

  // A zero result always takes the positive branch, so -0 cannot appear.
  function automatic logic [N-1:0] tc2sm(input logic signed [SW-1:0] v);
    return {v[SW-1], (N-1)'(v[SW-1] ? -v : v)};
  endfunction

  logic [AW-1:0] pre_age, post_age;
  logic          pre_valid, post_valid;
  logic          pre_only, post_only, pot, dep, ev;
  logic [AW-1:0] ev_age;
  logic [N-2:0]  ev_mag;
  logic [N-1:0]  ev_word;

  // age < WINDOW is the same test as distance (age + 1) <= WINDOW.
  assign pre_only  = tick & pre_spike & ~post_spike;
  assign post_only = tick & post_spike & ~pre_spike;
  assign pot       = post_only & pre_valid & (pre_age < AGE_MAX);
  assign dep       = pre_only & post_valid & (post_age < AGE_MAX);
  assign ev        = pot | dep;
  assign ev_age    = pot ? pre_age : post_age;
  assign ev_mag    = ((N-1)'(ev_age) + (N-1)'(1)) << Q;
  assign ev_word   = {dep, ev_mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_age    <= '0;
      post_age   <= '0;
      pre_valid  <= 1'b0;
      post_valid <= 1'b0;
    end else if (tick) begin
      if (pre_spike) begin
        pre_age   <= '0;
        pre_valid <= 1'b1;
      end else begin
        if (pre_age != AGE_MAX) pre_age <= pre_age + 1'b1;
        if (pot) pre_valid <= 1'b0;
      end
      if (post_spike) begin
        post_age   <= '0;
        post_valid <= 1'b1;
      end else begin
        if (post_age != AGE_MAX) post_age <= post_age + 1'b1;
        if (dep) post_valid <= 1'b0;
      end
    end
  end

  state_t       state, state_nx;
  logic         load_tc, ovf_set;
  logic [N-1:0] tc_nx, pend, pend_nx, dw_r;
  logic         pend_v, pend_v_nx;

  always_comb begin
    state_nx  = state;
    load_tc   = 1'b0;
    tc_nx     = ev_word;
    pend_v_nx = pend_v;
    pend_nx   = pend;
    ovf_set   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_v) begin
          state_nx  = APPLY;
          load_tc   = 1'b1;
          tc_nx     = pend;
          pend_v_nx = ev;
          if (ev) pend_nx = ev_word;
        end else if (ev) begin
          state_nx = APPLY;
          load_tc  = 1'b1;
        end
      end
      APPLY: begin
        state_nx = UPDATE;
        if (ev) begin
          if (PEND_EN && !pend_v) begin
            pend_v_nx = 1'b1;
            pend_nx   = ev_word;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      UPDATE: begin
        if (pend_v) begin
          state_nx  = APPLY;
          load_tc   = 1'b1;
          tc_nx     = pend;
          pend_v_nx = 1'b0;
          if (ev) ovf_set = 1'b1;
        end else if (ev && PEND_EN) begin
          // Empty slot: the new event passes straight through to APPLY.
          state_nx = APPLY;
          load_tc  = 1'b1;
        end else begin
          state_nx = IDLE;
          if (ev) ovf_set = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic signed [SW-1:0] sum, lo, hi, clamped;

  always_comb begin
    lo  = sm2tc(W_MIN);
    hi  = sm2tc(W_MAX);
    sum = sm2tc(weight) + sm2tc(dw_r);
    if (sum < lo)      clamped = lo;
    else if (sum > hi) clamped = hi;
    else               clamped = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      t_change <= '0;
      dw_r     <= '0;
      weight   <= W_INIT;
      pend     <= '0;
      pend_v   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nx;
      pend   <= pend_nx;
      pend_v <= pend_v_nx;
      if (load_tc)          t_change <= tc_nx;
      if (state == APPLY)   dw_r     <= dw;
      if (state == UPDATE)  weight   <= tc2sm(clamped);
      if (ovf_set)          overflow <= 1'b1;
    end
  end

  assign apply = (state == APPLY);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_stdp_pair_scheduler.sv
// Bench for stdp_pair_scheduler: directed vector table, hand sequences, and random ticks vs an index-based pair model.
module tb_stdp_pair_scheduler;

  logic        clk, rst_n, tick, pre_spike, post_spike;
  logic [31:0] dw, t_change, weight, stub_dw;
  logic        apply, busy, overflow;
  bit          use_fn   = 1'b0;
  bit          rnd_mode = 1'b0;

  int errs = 0, checks = 0;
  int n_apply = 0, consec = 0, cyc_n = 0, a1 = 0, a2 = 0;
  logic [31:0] last_tc = '0;
  bit   prev_apply = 1'b0;

  int exp_q[$];
  int m_w = 32'h8000, wchk = 0, mon_d = 0;

  stdp_pair_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pre_spike(pre_spike), .post_spike(post_spike),
    .dw(dw), .t_change(t_change), .apply(apply), .weight(weight), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dw_of(input logic [31:0] tc);
    logic [30:0] m;
    m = 31'(tc[30:16]) * 31'(2048);
    return {tc[31], m};
  endfunction

  assign dw = use_fn ? dw_of(t_change) : stub_dw;

  function automatic logic [31:0] enc(input int d);
    logic [14:0] m;
    m = 15'(d < 0 ? -d : d);
    return {(d < 0), m, 16'h0000};
  endfunction

  function automatic int clampw(input int v);
    if (v < 0) return 0;
    if (v > 65536) return 65536;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc_n++;
    if (rst_n) begin
      if (wchk > 0) begin
        wchk--;
        if (wchk == 0) check("rnd_weight", weight, 32'(m_w));
      end
      if (apply) begin
        n_apply++;
        last_tc = t_change;
        if (n_apply == 1) a1 = cyc_n;
        if (n_apply == 2) a2 = cyc_n;
        if (prev_apply) consec++;
        if (rnd_mode) begin
          if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL rnd_extra_apply: got t_change %h expected no apply", t_change);
          end else begin
            mon_d = exp_q.pop_front();
            check("rnd_t_change", t_change, enc(mon_d));
            m_w  = clampw(m_w + mon_d * 2048);
            wchk = 2;
          end
        end
      end
      prev_apply = apply;
    end else begin
      prev_apply = 1'b0;
    end
  end

  task automatic cyc(input logic t, input logic p, input logic q);
    tick = t; pre_spike = p; post_spike = q;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick = 1'b0; pre_spike = 1'b0; post_spike = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_apply = 0;
  endtask

  task automatic run_seq(input int last, input logic [127:0] pm, input logic [127:0] qm);
    for (int t = 0; t <= last; t++) begin
      cyc(1'b1, pm[t], qm[t]);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    int          pre_t;
    int          post_t;
    logic [31:0] dwv;
    int          n_exp;
    logic [31:0] tc_exp;
    logic [31:0] w_exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{10, 13, 32'h0000_1000, 1, 32'h0003_0000, 32'h0000_9000};
    vecs[1] = '{ 7,  5, 32'h8000_4000, 1, 32'h8002_0000, 32'h0000_4000};
    vecs[2] = '{ 0, 65, 32'h0000_1000, 0, 32'h0000_0000, 32'h0000_8000};
    vecs[3] = '{ 0, 64, 32'h0000_4000, 1, 32'h0040_0000, 32'h0000_c000};
    vecs[4] = '{ 3,  4, 32'h8002_0000, 1, 32'h0001_0000, 32'h0000_0000};
    vecs[5] = '{ 3,  4, 32'h0001_0000, 1, 32'h0001_0000, 32'h0001_0000};
    vecs[6] = '{ 3,  4, 32'h8000_0000, 1, 32'h0001_0000, 32'h0000_8000};
    vecs[7] = '{ 4,  4, 32'h0000_1000, 0, 32'h0000_0000, 32'h0000_8000};

    stub_dw = '0;
    rst_n = 1'b0;
    tick = 1'b0; pre_spike = 1'b0; post_spike = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_t_change", t_change, 32'h0);
    check("rst_apply", {31'b0, apply}, 32'h0);
    check("rst_weight", weight, 32'h0000_8000);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_overflow", {31'b0, overflow}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      int last;
      do_reset();
      stub_dw = vecs[i].dwv;
      last = (vecs[i].pre_t > vecs[i].post_t ? vecs[i].pre_t : vecs[i].post_t) + 1;
      run_seq(last, 128'd1 << vecs[i].pre_t, 128'd1 << vecs[i].post_t);
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d_napply", i), 32'(n_apply), 32'(vecs[i].n_exp));
      if (vecs[i].n_exp > 0) check($sformatf("vec%0d_t_change", i), last_tc, vecs[i].tc_exp);
      check($sformatf("vec%0d_weight", i), weight, vecs[i].w_exp);
      check($sformatf("vec%0d_overflow", i), {31'b0, overflow}, 32'h0);
    end

    // Exact cycle timing: pre at tick 10, post on tick 13 driven by hand.
    do_reset();
    stub_dw = 32'h0000_1000;
    run_seq(12, 128'd1 << 10, '0);
    cyc(1'b1, 1'b0, 1'b1);
    check("tim_apply_c1", {31'b0, apply}, 32'h1);
    check("tim_tc_c1", t_change, 32'h0003_0000);
    check("tim_busy_c1", {31'b0, busy}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    check("tim_apply_c2", {31'b0, apply}, 32'h0);
    check("tim_busy_c2", {31'b0, busy}, 32'h1);
    check("tim_weight_c2", weight, 32'h0000_8000);
    check("tim_tc_hold_c2", t_change, 32'h0003_0000);
    cyc(1'b0, 1'b0, 1'b0);
    check("tim_weight_c3", weight, 32'h0000_9000);
    check("tim_busy_c3", {31'b0, busy}, 32'h0);

    // Same-tick spikes issue nothing, then a later post pairs at distance 2.
    do_reset();
    stub_dw = 32'h0;
    run_seq(4, 128'd1 << 4, 128'd1 << 4);
    check("same_tick_napply", 32'(n_apply), 32'h0);
    run_seq(1, '0, 128'd1 << 1);
    check("after_same_napply", 32'(n_apply), 32'h1);
    check("after_same_tc", last_tc, 32'h0002_0000);

    // Weight pinned at W_MAX stays there under a further +0.25.
    do_reset();
    stub_dw = 32'h0001_0000;
    run_seq(2, 128'd1 << 1, 128'd1 << 2);
    check("sat_hi_first", weight, 32'h0001_0000);
    stub_dw = 32'h0000_4000;
    run_seq(1, 128'd1 << 1, '0);
    check("sat_hi_napply", 32'(n_apply), 32'h2);
    check("sat_hi_tc", last_tc, 32'h8002_0000);
    check("sat_hi_weight", weight, 32'h0001_0000);

    // Three pair events on consecutive ticks.
    do_reset();
    stub_dw = 32'h0000_1000;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    check("burst_overflow", {31'b0, overflow}, 32'h1);
`ifdef STDP_PENDING_EN
    check("burst_napply", 32'(n_apply), 32'h2);
    check("burst_spacing", 32'(a2 - a1), 32'h2);
    check("burst_last_tc", last_tc, 32'h8001_0000);
    check("burst_weight", weight, 32'h0000_a000);
`else
    check("burst_napply", 32'(n_apply), 32'h1);
    check("burst_last_tc", last_tc, 32'h0001_0000);
    check("burst_weight", weight, 32'h0000_9000);
`endif

    // Reset asserted during APPLY discards the in-flight event.
    cyc(1'b1, 1'b1, 1'b0);
    check("rst_mid_apply_before", {31'b0, apply}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_apply", {31'b0, apply}, 32'h0);
    check("rst_mid_weight", weight, 32'h0000_8000);
    check("rst_mid_overflow", {31'b0, overflow}, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n_apply = 0;
    repeat (8) cyc(1'b0, 1'b0, 1'b0);
    check("rst_mid_no_late_apply", 32'(n_apply), 32'h0);
    check("rst_mid_weight_after", weight, 32'h0000_8000);

    // Random spikes, ticks spaced so no event ever meets a busy scheduler.
    do_reset();
    use_fn = 1'b1;
    rnd_mode = 1'b1;
    m_w = 32'h8000;
    consec = 0;
    begin
      int lp, lq, pp;
      bit pv, qv, p, q;
      pv = 1'b0; qv = 1'b0; lp = 0; lq = 0;
      for (int t = 0; t < 400; t++) begin
        pp = (t < 200) ? 30 : 3;
        p = ($urandom_range(0, 99) < pp);
        q = ($urandom_range(0, 99) < pp);
        if (p && q) begin
          lp = t; lq = t; pv = 1'b1; qv = 1'b1;
        end else if (q) begin
          if (pv && (t - lp) <= 64) begin exp_q.push_back(t - lp); pv = 1'b0; end
          lq = t; qv = 1'b1;
        end else if (p) begin
          if (qv && (t - lq) <= 64) begin exp_q.push_back(-(t - lq)); qv = 1'b0; end
          lp = t; pv = 1'b1;
        end
        cyc(1'b1, p, q);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
      end
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    check("rnd_unissued_pairs", 32'(exp_q.size()), 32'h0);
    check("rnd_final_weight", weight, 32'(m_w));
    check("rnd_overflow", {31'b0, overflow}, 32'h0);
    check("rnd_no_consec_apply", 32'(consec), 32'h0);
    rnd_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/stdp_pair_scheduler.md
# stdp_pair_scheduler

Spike-timing front end for the STDP weight-change calculator. Tracks the most recent pre- and post-synaptic spike of one synapse on the neuron timestep strobe and forms nearest-neighbour spike pairs. For each pair it drives the signed spike-time difference and a one-cycle `apply` into the calculator. It then takes the returned `dw` and folds it into the synapse weight it owns, with saturation.

## Interface
- `N`, 32: word width; sign-magnitude fixed point, bit N-1 = sign.
- `Q`, 16: fractional bits.
- `WINDOW`, 64: maximum pairing distance in ticks; larger gaps produce no pair.
- `W_MIN`, 32'h0000_0000: lower weight clamp (0.0), sign-magnitude.
- `W_MAX`, 32'h0001_0000: upper weight clamp (1.0).
- `W_INIT`, 32'h0000_8000: reset weight (0.5).

- `clk`  in  1  clock; one clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  timestep strobe; spikes are sampled only when high.
- `pre_spike`  in  1  pre-synaptic spike for this timestep.
- `post_spike`  in  1  post-synaptic spike for this timestep.
- `dw`  in  N  weight change returned by the calculator (combinational from `t_change`/`apply`).
- `t_change`  out  N  spike-time difference (t_post − t_pre), fixed point.
- `apply`  out  1  one-cycle request; `t_change` is valid while high.
- `weight`  out  N  current synapse weight.
- `busy`  out  1  high in APPLY/UPDATE.
- `overflow`  out  1  sticky; a pair event was lost. Cleared only by reset.

## Operation
- Per side: `pre_age`/`post_age` counters, `pre_valid`/`post_valid` flags.
- Ages advance only on `tick`.
- On a spike tick the own age is set to 0 and valid to 1. Otherwise age increments, saturating at WINDOW.
- Pair distance is `age_reg + 1` ticks, using the register value sampled in the spike-tick cycle.
- Post spike with `pre_valid` and distance ≤ WINDOW:
  - event with positive difference (potentiation);
  - clear `pre_valid`.
- Pre spike with `post_valid` and distance ≤ WINDOW:
  - event with negative difference (depression);
  - clear `post_valid`.
- Pre and post on the same tick:
  - no event (Δt = 0 is never issued);
  - both ages go to 0 and both valids to 1.
- Difference encoding: {sign, distance in integer bits [N-2:Q], Q zero fraction bits}. Negative zero is never produced.
- FSM states:
  - IDLE → APPLY on event, or on a pending entry.
  - APPLY: drive `apply=1` and `t_change`; register `dw` into `dw_r`.
  - UPDATE: `weight <= clamp(weight + dw_r, W_MIN, W_MAX)`.
  - UPDATE → APPLY if pending is valid, else → IDLE.
- Arithmetic:
  - Convert sign-magnitude operands to N+1-bit two's complement, add, clamp, convert back.
  - `dw` of ±0 leaves `weight` unchanged.
  - The result is never negative zero.
- Event while busy: stored in a 1-entry pending register.
- Event while busy with pending already full: the event is dropped and `overflow` is set.
- Reset values: `t_change`=0, `apply`=0, `weight`=W_INIT, `busy`=0, `overflow`=0; ages 0, valids 0, pending empty, state IDLE.

## Timing
- Event on tick in cycle c (IDLE): `apply`=1 and `t_change` valid in c+1; `dw` sampled at the end of c+1.
- UPDATE in c+2; new `weight` visible from c+3; `busy` high c+1..c+2.
- Pending entry: APPLY in c+3, UPDATE in c+4, weight visible c+5.
- Throughput: one pair per 2 cycles.
- `apply` is never high on two consecutive cycles.
- `t_change` holds its last value while `apply`=0.
- Ticks in APPLY/UPDATE still advance ages and valids normally.
- Reset mid-operation: all state goes to reset values immediately. Any in-flight or pending update is discarded, and `apply` drops asynchronously.

## Configuration
- `STDP_PENDING_EN` defined: the 1-entry pending register is present, as described above.
- `STDP_PENDING_EN` undefined: no pending register. Any event arriving while `busy` is dropped and sets `overflow`, so a back-to-back pair two cycles apart is lost.

## Test plan
- Pre at tick 10, post at tick 13, stub `dw`=32'h0000_1000 when `apply` → one `apply` pulse with `t_change`=32'h0003_0000; `weight` 32'h0000_8000→32'h0000_9000 two cycles later.
- Post at tick 5, pre at tick 7, stub `dw`=32'h8000_4000 → `t_change`=32'h8002_0000; `weight` becomes 32'h0000_4000.
- Pre and post both on tick 4 → no `apply`; a later post at tick 6 pairs with pre at distance 2 → `t_change`=32'h0002_0000.
- Pre at tick 0, post at tick 65 (WINDOW=64) → no `apply`. With `weight` at W_MAX and `dw`=+0.25 → `weight` stays 32'h0001_0000. With `dw`=−2.0 from 0.5 → `weight` 32'h0000_0000.
- Ticks every cycle, three pair events in consecutive cycles → with macro: two applied, third sets `overflow`; without macro: one applied, `overflow`=1.
- Assert `rst_n`=0 during APPLY → `apply` drops immediately, `weight`=W_INIT, `overflow`=0, no later `apply` from the old event.
